// File: rtl/wave_capture_mc_pkg.sv
// Shared definitions for the multi-channel wave capture stage: FSM encodings,
// display conversion helper and default geometry shared with the display/RAM pair.
package wave_capture_mc_pkg;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } cap_state_t;

  localparam int DEF_DEPTH  = 9;
  localparam int DEF_DISP_W = 8;

  // Signed top bits become offset-binary by flipping the sign bit of the field.
  function automatic logic [31:0] to_display(input logic [31:0] top, input int unsigned width);
    return top ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/wave_capture_mc_decimator.sv
// Sample decimator: passes one of every decim+1 new_sample strobes as an accept strobe.
module wave_capture_mc_decimator #(
  parameter int DECIM_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_sample,
  input  logic [DECIM_W-1:0] decim,
  output logic               accept
);

  logic [DECIM_W-1:0] decim_cnt;

  // >= rather than == so a ratio lowered below the running count cannot stall.
  assign accept = new_sample && (decim_cnt >= decim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decim_cnt <= '0;
    end else if (new_sample) begin
      decim_cnt <= accept ? '0 : decim_cnt + DECIM_W'(1);
    end
  end

endmodule

// File: rtl/wave_capture_mc.sv
// Multi-channel triggered wave capture: decimates, triggers on a selected channel's
// rising zero crossing and fills the non-displayed half of a ping-pong sample RAM.
module wave_capture_mc
  import wave_capture_mc_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int SAMPLE_W = 18,
  parameter int DISP_W   = DEF_DISP_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int DECIM_W  = 4,
  parameter int CH_W     = $clog2(NCH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_sample,
  input  logic [NCH*SAMPLE_W-1:0]   sample,
  input  logic [CH_W-1:0]           trig_ch,
  input  logic                      auto_mode,
  input  logic [DECIM_W-1:0]        decim,
  input  logic                      display_idle,
  output logic                      write_enable,
  output logic [DEPTH:0]            write_address,
  output logic [NCH*DISP_W-1:0]     write_sample,
  output logic                      read_index,
  output logic                      capturing,
  output logic                      triggered
);

  localparam int LSB_W = SAMPLE_W - DISP_W;

  logic                      vld_p0;
  logic [NCH*DISP_W-1:0]     disp_p0;
  logic [NCH-1:0]            msb_p0;
  logic [NCH*LSB_W-1:0]      lsb_p0;
  logic                      trig_neg_p0;
  logic                      xing_p0;
  logic                      force_p0;

  cap_state_t                state;
  logic                      prev_neg;
  logic [DEPTH-1:0]          timeout;
  logic [DEPTH-1:0]          idx;
  logic                      unused_lsbs;

  wave_capture_mc_decimator #(
    .DECIM_W (DECIM_W)
  ) u_decim (
    .clk        (clk),
    .reset      (reset),
    .new_sample (new_sample),
    .decim      (decim),
    .accept     (vld_p0)
  );

  // ---- stage p0: per-channel conversion and trigger detection (combinational)
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [SAMPLE_W-1:0] ch_sample;
    assign ch_sample = sample[c*SAMPLE_W +: SAMPLE_W];
    assign msb_p0[c] = ch_sample[SAMPLE_W-1];
    assign disp_p0[c*DISP_W +: DISP_W] =
      DISP_W'(to_display(32'(ch_sample[SAMPLE_W-1 -: DISP_W]), DISP_W));
    assign lsb_p0[c*LSB_W +: LSB_W] = ch_sample[LSB_W-1:0];
  end

  // Sample bits below the display field are discarded by design.
  assign unused_lsbs = ^lsb_p0;

  assign trig_neg_p0 = msb_p0[trig_ch];
  assign xing_p0     = prev_neg && !trig_neg_p0;
  assign force_p0    = auto_mode && (timeout == '1);

  // ---- stage p1: FSM, address counter and registered RAM write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_ARMED;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      capturing     <= 1'b0;
      triggered     <= 1'b0;
      timeout       <= '0;
      prev_neg      <= 1'b0;
      idx           <= '0;
    end else begin
      write_enable <= 1'b0;
      triggered    <= 1'b0;
      if (vld_p0) begin
        prev_neg <= trig_neg_p0;
      end
      case (state)
        ST_ARMED: begin
          if (vld_p0) begin
            if (xing_p0 || force_p0) begin
              write_enable  <= 1'b1;
              write_address <= {~read_index, {DEPTH{1'b0}}};
              write_sample  <= disp_p0;
              triggered     <= 1'b1;
              capturing     <= 1'b1;
              timeout       <= '0;
              idx           <= DEPTH'(1);
              state         <= ST_ACTIVE;
            end else begin
              timeout <= timeout + DEPTH'(1);
            end
          end
        end
        ST_ACTIVE: begin
          if (vld_p0) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, idx};
            write_sample  <= disp_p0;
            idx           <= idx + DEPTH'(1);
            if (idx == '1) begin
              capturing <= 1'b0;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A sample arriving with the flip only refreshes prev_neg above.
          if (display_idle) begin
            read_index <= ~read_index;
            state      <= ST_ARMED;
          end
        end
        default: begin
          capturing <= 1'b0;
          state     <= ST_ARMED;
        end
      endcase
    end
  end

endmodule
